// File: rtl/hyper_mvblck_pkg.sv
// Shared types and helpers for the mvblck-to-DRAM mover family.
package hyper_mvblck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int LANES_DEF = 2;
  localparam int LANE_W    = $clog2(LANES_DEF);

  function automatic int lane_width(input int lanes);
    return $clog2(lanes);
  endfunction

  // Clears the lane-index bits so the address points at the start of its beat.
  function automatic logic [31:0] beat_align(input logic [31:0] addr, input int lane_w);
    return addr & ~((32'd1 << lane_w) - 32'd1);
  endfunction

endpackage

// File: rtl/hyper_mvblck_todram_multi_if.sv
// LSAB section port and MCU collation port bundled for the mover.
interface hyper_mvblck_todram_multi_if #(
  parameter int NSEC   = 4,
  parameter int SEC_W  = 2,
  parameter int LANES  = 2,
  parameter int ADDR_W = 9,
  parameter int ANC_W  = 25,
  parameter int SEL_W  = 2
);
  logic [NSEC-1:0]       LSAB_INT;
  logic [NSEC-1:0]       LSAB_STOP;
  logic [NSEC-1:0]       LSAB_EMPTY;
  logic [NSEC*ANC_W-1:0] LSAB_ANCILL;
  logic                  LSAB_READ;
  logic [SEC_W-1:0]      LSAB_SECTION;
  logic [ADDR_W-1:0]     MCU_COLL_ADDRESS;
  logic [2*LANES-1:0]    MCU_WE_ARRAY;
  logic [SEL_W-1:0]      MCU_REQUEST_ACCESS;

  modport master (
    input  LSAB_INT, LSAB_STOP, LSAB_EMPTY, LSAB_ANCILL,
    output LSAB_READ, LSAB_SECTION,
    output MCU_COLL_ADDRESS, MCU_WE_ARRAY, MCU_REQUEST_ACCESS
  );

  modport slave (
    output LSAB_INT, LSAB_STOP, LSAB_EMPTY, LSAB_ANCILL,
    input  LSAB_READ, LSAB_SECTION,
    input  MCU_COLL_ADDRESS, MCU_WE_ARRAY, MCU_REQUEST_ACCESS
  );
endinterface

// File: rtl/hyper_lsab_sel.sv
// Per-section mux of LSAB status and ancillary data; tolerates non-power-of-2 NSEC.
module hyper_lsab_sel
  import hyper_mvblck_pkg::*;
#(
  parameter int NSEC  = 4,
  parameter int SEC_W = 2,
  parameter int ANC_W = 25
) (
  input  logic [SEC_W-1:0]      sec,
  input  logic [NSEC-1:0]       stop_v,
  input  logic [NSEC-1:0]       int_v,
  input  logic [NSEC-1:0]       empty_v,
  input  logic [NSEC*ANC_W-1:0] ancill_v,
  output logic                  stop_o,
  output logic                  int_o,
  output logic                  empty_o,
  output logic [ANC_W-1:0]      ancill_o
);
  always_comb begin
    stop_o   = 1'b0;
    int_o    = 1'b0;
    empty_o  = 1'b0;
    ancill_o = '0;
    for (int k = 0; k < NSEC; k++) begin
      if (sec == SEC_W'(k)) begin
        stop_o   = stop_v[k];
        int_o    = int_v[k];
        empty_o  = empty_v[k];
        ancill_o = ancill_v[k*ANC_W +: ANC_W];
      end
    end
  end
endmodule

// File: rtl/hyper_mvblck_todram_multi.sv
// Moves a block of LSAB words into DRAM, packing LANES words per collation beat.
module hyper_mvblck_todram_multi
  import hyper_mvblck_pkg::*;
#(
  parameter int NSEC     = 4,
  parameter int SEC_W    = 2,
  parameter int LANES    = 2,
  parameter int ADDR_W   = 9,
  parameter int CNT_W    = 6,
  parameter int ANC_W    = 25,
  parameter int SEL_W    = 2,
  parameter int WORK_DLY = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  hyper_mvblck_todram_multi_if.master bus,
  input  logic [ADDR_W-1:0]          START_ADDRESS,
  input  logic [CNT_W-1:0]           COUNT_REQ,
  input  logic [SEC_W-1:0]           SECTION,
  input  logic [SEL_W-1:0]           DRAM_SEL,
  input  logic                       ISSUE,
  output logic [CNT_W-1:0]           COUNT_SENT,
  output logic                       WORKING,
  output logic                       DONE,
  output logic                       IRQ_OUT,
  output logic                       ABRUPT_STOP,
  output logic [ANC_W-1:0]           ANCILL_OUT
);
  localparam int LN_W = lane_width(LANES);
  localparam int WE_W = 2 * LANES;
  localparam logic [LN_W-1:0] LAST_LANE = LN_W'(LANES - 1);
  localparam logic [WE_W-1:0] MSB_PAIR  = {2'b11, {(WE_W-2){1'b0}}};

  state_e state_q, state_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [CNT_W-1:0]    len_q, len_d, creq_q, creq_d, cnt_sent_q, cnt_sent_d;
  logic [ADDR_W-1:0]   track_q, track_d, mcu_addr_q, mcu_addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d, mcu_req_q, mcu_req_d;
  logic [WE_W-1:0]     we_acc_q, we_acc_d, mcu_we_q, mcu_we_d;
  logic                read_q, read_d, stop_pend_q, stop_pend_d;
  logic                irq_q, irq_d, abrupt_q, abrupt_d;
  logic [ANC_W-1:0]    anc_q, anc_d;
  logic [WORK_DLY-1:0] dly_q, dly_d;

  logic            stop_sel, int_sel, empty_sel;
  logic [ANC_W-1:0] anc_sel;
  logic [LN_W-1:0] lane;
  logic            last, accept, term, fin, fin_abrupt, emit;
  logic [WE_W-1:0] slot_we, emit_we;

  hyper_lsab_sel #(.NSEC(NSEC), .SEC_W(SEC_W), .ANC_W(ANC_W)) u_sel (
    .sec      (sec_q),
    .stop_v   (bus.LSAB_STOP),
    .int_v    (bus.LSAB_INT),
    .empty_v  (bus.LSAB_EMPTY),
    .ancill_v (bus.LSAB_ANCILL),
    .stop_o   (stop_sel),
    .int_o    (int_sel),
    .empty_o  (empty_sel),
    .ancill_o (anc_sel)
  );

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    len_d       = len_q;
    creq_d      = creq_q;
    track_d     = track_q;
    sel_d       = sel_q;
    read_d      = read_q;
    we_acc_d    = we_acc_q;
    stop_pend_d = stop_pend_q;
    cnt_sent_d  = cnt_sent_q;
    irq_d       = irq_q;
    abrupt_d    = abrupt_q;
    anc_d       = anc_q;
    mcu_addr_d  = '0;
    mcu_we_d    = '0;
    mcu_req_d   = '0;
    lane        = track_q[LN_W-1:0];
    last        = (lane == LAST_LANE);
    accept      = read_q && !stop_sel;
    term        = 1'b0;
    fin         = 1'b0;
    fin_abrupt  = 1'b0;
    emit        = 1'b0;
    emit_we     = '0;
    // Earliest lane sits in the MSB pair, hence the right shift by lane index.
    slot_we     = we_acc_q | (accept ? (MSB_PAIR >> {lane, 1'b0}) : '0);
    dly_d       = (dly_q << 1) | WORK_DLY'(state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        sec_d       = SECTION;
        len_d       = COUNT_REQ;
        creq_d      = COUNT_REQ;
        track_d     = START_ADDRESS;
        sel_d       = DRAM_SEL;
        we_acc_d    = '0;
        stop_pend_d = 1'b0;
        if (ISSUE) begin
          if (COUNT_REQ == '0) fin = 1'b1;
          else                 state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        read_d = 1'b0;
        if (stop_sel) begin
          fin        = 1'b1;
          fin_abrupt = 1'b1;
        end else if (!empty_sel) begin
          read_d  = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        track_d  = track_q + ADDR_W'(1);
        we_acc_d = slot_we;
        if (accept) len_d = len_q - CNT_W'(1);
        term   = (accept && len_q == CNT_W'(1)) || (read_q && stop_sel);
        read_d = !term;
        if (last) begin
          emit     = 1'b1;
          emit_we  = slot_we;
          we_acc_d = '0;
        end
        if (term) begin
          stop_pend_d = stop_sel;
          if (last) begin
            fin        = 1'b1;
            fin_abrupt = stop_sel;
          end else begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        track_d = track_q + ADDR_W'(1);
        if (last) begin
          emit       = 1'b1;
          emit_we    = we_acc_q;
          we_acc_d   = '0;
          fin        = 1'b1;
          fin_abrupt = stop_pend_q;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (emit) begin
      mcu_addr_d = ADDR_W'(beat_align(32'(track_q), LN_W));
      mcu_we_d   = emit_we;
      mcu_req_d  = sel_q;
    end
    if (fin) begin
      state_d    = ST_DONE;
      cnt_sent_d = creq_d - len_d;
      abrupt_d   = fin_abrupt;
      irq_d      = int_sel;
      anc_d      = anc_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      sec_q       <= '0;
      len_q       <= '0;
      creq_q      <= '0;
      track_q     <= '0;
      sel_q       <= '0;
      read_q      <= 1'b0;
      we_acc_q    <= '0;
      stop_pend_q <= 1'b0;
      cnt_sent_q  <= '0;
      irq_q       <= 1'b0;
      abrupt_q    <= 1'b0;
      anc_q       <= '0;
      mcu_addr_q  <= '0;
      mcu_we_q    <= '0;
      mcu_req_q   <= '0;
      dly_q       <= '0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      len_q       <= len_d;
      creq_q      <= creq_d;
      track_q     <= track_d;
      sel_q       <= sel_d;
      read_q      <= read_d;
      we_acc_q    <= we_acc_d;
      stop_pend_q <= stop_pend_d;
      cnt_sent_q  <= cnt_sent_d;
      irq_q       <= irq_d;
      abrupt_q    <= abrupt_d;
      anc_q       <= anc_d;
      mcu_addr_q  <= mcu_addr_d;
      mcu_we_q    <= mcu_we_d;
      mcu_req_q   <= mcu_req_d;
      dly_q       <= dly_d;
    end
  end

  assign bus.LSAB_READ          = read_q;
  assign bus.LSAB_SECTION       = sec_q;
  assign bus.MCU_COLL_ADDRESS   = mcu_addr_q;
  assign bus.MCU_WE_ARRAY       = mcu_we_q;
  assign bus.MCU_REQUEST_ACCESS = mcu_req_q;
  assign COUNT_SENT             = cnt_sent_q;
  assign WORKING                = dly_q[WORK_DLY-1];
  assign DONE                   = (state_q == ST_DONE);
  assign IRQ_OUT                = irq_q;
  assign ABRUPT_STOP            = abrupt_q;
  assign ANCILL_OUT             = anc_q;
endmodule
